// File: rtl/adc_scan_averager.sv
// adc_scan_averager: scans N_CH mux channels through an ADC0804-style
// converter, averages each burst and drives a hysteresis alarm LED.
module adc_scan_averager #(
  parameter int DATA_W      = 8,
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int AVG_LOG2    = 2,
  parameter int WR_LOW_CYC  = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 1023,
  parameter int ALARM_HI    = 160,
  parameter int ALARM_LO    = 150
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  input  logic              intr,
  input  logic [DATA_W-1:0] adc,
  output logic              wr,
  output logic [CH_W-1:0]   ch_sel,
  output logic              avg_valid,
  output logic [CH_W-1:0]   avg_ch,
  output logic [DATA_W-1:0] avg_data,
  output logic              led_state,
  output logic              timeout_err,
  output logic              busy
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int T_A   = (SETTLE_CYC > WR_LOW_CYC) ?
                         SETTLE_CYC : WR_LOW_CYC;
  localparam int T_MAX = (TIMEOUT_CYC > T_A) ? TIMEOUT_CYC : T_A;
  localparam int TMR_W = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WR_LAST     = TMR_W'(WR_LOW_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(1 << AVG_LOG2);
  localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(N_CH - 1);
  localparam logic [DATA_W-1:0] HI         = DATA_W'(ALARM_HI);
  localparam logic [DATA_W-1:0] LO         = DATA_W'(ALARM_LO);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_LATCH
  } state_t;

  state_t state;
  state_t state_n;

  logic              intr_m;
  logic              intr_s;
  logic [TMR_W-1:0]  tmr;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [N_CH-1:0]   flags;

  logic              take;
  logic              publish;
  logic              tmo;
  logic [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] avg;
  logic [CH_W-1:0]   ch_nxt;
  logic [N_CH-1:0]   flags_n;

  // intr comes straight from the converter, unrelated to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intr_m <= 1'b0;
      intr_s <= 1'b0;
    end else begin
      intr_m <= intr;
      intr_s <= intr_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    publish = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (scan_en) state_n = S_SETTLE;
      end
      S_SETTLE: begin
        if (tmr == SETTLE_LAST) state_n = S_START;
      end
      S_START: begin
        if (tmr == WR_LAST) state_n = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (intr_s) begin
          state_n = S_WAIT_LO;
        end else if (tmr == TMO_LAST) begin
          tmo     = 1'b1;
          state_n = S_SETTLE;
        end
      end
      S_WAIT_LO: begin
        if (!intr_s) begin
          state_n = S_LATCH;
        end else if (tmr == TMO_LAST) begin
          tmo     = 1'b1;
          state_n = S_SETTLE;
        end
      end
      S_LATCH: begin
        take = 1'b1;
        if (cnt_inc == CNT_FULL) begin
          publish = 1'b1;
          state_n = scan_en ? S_SETTLE : S_IDLE;
        end else begin
          state_n = S_START;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // one shared phase timer, restarted on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    tmr <= '0;
    else if (state_n != state)  tmr <= '0;
    else if (state != S_IDLE)   tmr <= tmr + 1'b1;
  end

  always_comb begin
    sum     = acc + ACC_W'(adc);
    cnt_inc = cnt + 1'b1;
    avg     = sum[ACC_W-1:AVG_LOG2];
    ch_nxt  = (ch_sel == CH_LAST) ? '0 : ch_sel + 1'b1;
    flags_n = flags;
    if (avg >= HI)      flags_n[ch_sel] = 1'b1;
    else if (avg <= LO) flags_n[ch_sel] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr          <= 1'b1;
      busy        <= 1'b0;
      ch_sel      <= '0;
      avg_valid   <= 1'b0;
      avg_ch      <= '0;
      avg_data    <= '0;
      led_state   <= 1'b0;
      timeout_err <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      flags       <= '0;
    end else begin
      wr        <= (state_n != S_START);
      busy      <= (state_n != S_IDLE);
      avg_valid <= publish;
      if (tmo) begin
        timeout_err <= 1'b1;
        acc         <= '0;
        cnt         <= '0;
      end else if (publish) begin
        avg_ch    <= ch_sel;
        avg_data  <= avg;
        flags     <= flags_n;
        led_state <= |flags_n;
        ch_sel    <= ch_nxt;
        acc       <= '0;
        cnt       <= '0;
      end else if (take) begin
        acc <= sum;
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: doc/adc_scan_averager.md
Name: adc_scan_averager

Overview:
- Parametrised successor to the single-channel ADC front end of the temperature sensor.
- Drives an ADC0804-style converter (active-low wr start, intr handshake) through an external analog mux over N_CH channels.
- Averages 2^AVG_LOG2 consecutive samples per channel and publishes one result per channel burst.
- Drives led_state from a per-channel hysteresis alarm; the downstream LCD formatter consumes avg_valid/avg_ch/avg_data.

Parameters:
DATA_W, 8, ADC sample width
N_CH, 4, number of mux channels (>=1)
CH_W, 2, channel index width; must equal max(1, ceil(log2(N_CH)))
AVG_LOG2, 2, log2 of samples per average (0 = no averaging)
WR_LOW_CYC, 4, wr low pulse width in clk cycles (>=1)
SETTLE_CYC, 8, cycles after ch_sel change before start (>=1)
TIMEOUT_CYC, 1023, max cycles in each intr wait phase
ALARM_HI, 160, alarm set threshold (DATA_W bits)
ALARM_LO, 150, alarm clear threshold, must be < ALARM_HI

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset
scan_en  in  1  level; 1 = keep scanning
intr  in  1  ADC handshake: rises on start ack, falls when adc valid (asynchronous)
adc  in  DATA_W  ADC data, valid after intr falls
wr  out  1  active-low conversion start
ch_sel  out  CH_W  mux select
avg_valid  out  1  one-cycle pulse, result valid
avg_ch  out  CH_W  channel of result
avg_data  out  DATA_W  averaged sample
led_state  out  1  OR of per-channel alarm flags
timeout_err  out  1  sticky handshake-timeout flag
busy  out  1  FSM not in IDLE

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high. All outputs are registered.
- Reset values: wr=1, ch_sel=0, avg_valid=0, avg_ch=0, avg_data=0, led_state=0, timeout_err=0, busy=0. Accumulator, sample count, alarm flags and timers are cleared. State is IDLE.
- intr passes through a 2-flop synchroniser. All handshake decisions use the synchronised value intr_s.
- FSM states:
  - IDLE: leaves to SETTLE when scan_en=1.
  - SETTLE: waits SETTLE_CYC cycles, then goes to START.
  - START: wr=0 for exactly WR_LOW_CYC cycles, then wr=1 and go to WAIT_HI.
  - WAIT_HI: waits for intr_s=1, then goes to WAIT_LO.
  - WAIT_LO: waits for intr_s=0, then goes to LATCH.
  - LATCH: one cycle. Captures adc and adds it into the accumulator (width DATA_W+AVG_LOG2, cannot overflow). Increments the sample count.
    - If count < 2^AVG_LOG2: return to START. There is no re-settle within a burst.
    - Otherwise, in the next cycle: avg_valid=1, avg_ch=ch_sel, avg_data=acc>>AVG_LOG2 (truncating). Accumulator and count clear. Alarm flag[ch] is updated. ch_sel advances, wrapping N_CH-1 -> 0. Next state is SETTLE if scan_en=1, else IDLE.
- Alarm update:
  - flag[ch] sets when avg >= ALARM_HI.
  - flag[ch] clears when avg <= ALARM_LO.
  - Otherwise flag[ch] holds.
  - led_state updates in the same cycle as avg_valid.
- Timeout: a per-phase counter runs in WAIT_HI and WAIT_LO. If it reaches TIMEOUT_CYC:
  - timeout_err is set; only rst clears it.
  - The current burst is discarded: accumulator and count clear, no avg_valid.
  - ch_sel is unchanged.
  - Next state is SETTLE, which retries the same channel.
- scan_en going low mid-burst does not abort the burst. The burst completes and publishes, then the FSM goes to IDLE. ch_sel is retained for the next scan.
- N_CH=1: ch_sel stays 0 and bursts repeat on channel 0.
- Reset asserted in any state: all outputs take their reset values immediately, with no wait for a clock edge. wr returns high at once.

Test Plan:
- ADC model: wr low -> intr=1 after 3 cycles. intr holds 350 cycles, then adc updates and intr=0. Defaults, adc=8'h95 fixed, scan_en=1 -> avg_valid pulses for ch 0,1,2,3,0, each avg_data=8'h95. Exactly 4 wr low pulses per burst, each 4 cycles wide. SETTLE gap only between bursts.
- Truncation: ch0 samples 10,11,11,11 -> avg_data=10 (43>>2). All 255 -> avg_data=255, no overflow.
- Hysteresis on ch1: avg 165 -> led_state=1; then 155 -> stays 1; then 150 -> 0. Other channels stay at 100.
- Timeout: model never raises intr -> timeout_err=1 at TIMEOUT_CYC cycles into WAIT_HI. No avg_valid. wr re-pulses after SETTLE_CYC with ch_sel unchanged.
- rst pulsed during WAIT_LO of ch2 -> wr=1 and all outputs reset without a clock edge. After release, scanning restarts at ch 0.
- scan_en dropped after sample 2 of ch3 -> burst completes, avg_ch=3 published, busy=0 next cycle, ch_sel=0, wr stays 1 until scan_en returns.
